exp_bias_add: RTL
=================

Name: exp_bias_add

Overview:
- Downstream consumer of the expand bias controller's bias RAM.
- Streams bias words out of that RAM and adds them lane-wise to expand-layer accumulator beats.
- Emits saturated 16-bit results to the output packer.
- Prefetches bias words into a small FIFO to hide RAM read latency, so it sustains one beat per cycle.

Parameters:
BIAS_LAT, 2, cycles from a bias_req_o pulse (or the priming token) to the addressed word on bias_data_i
BIAS_FIFO_DEPTH, 4, bias prefetch FIFO entries; must be >= BIAS_LAT+1 for full throughput

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle pulse: latch config, restart block
no_of_exp_kernals_i  in  6  bias words per pixel minus 1 (N)
no_of_out_pixels_i  in  16  output pixels minus 1 (P)
bias_ram_ready_i  in  1  bias RAM loaded; address 0 presented
bias_req_o  out  1  advance controller read address by one (wraps at N in the controller)
bias_data_i  in  64  current bias word, 4 signed 16-bit lanes, lane k = [16k+15:16k]
acc_valid_i  in  1  accumulator beat valid
acc_ready_o  out  1  accumulator beat accepted when valid&ready
acc_data_i  in  64  4 signed 16-bit accumulator lanes
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts
out_data_o  out  64  4 signed 16-bit result lanes
busy_o  out  1  high from start_i until done
done_o  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset values: bias_req_o=0, acc_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0. The FIFO, token line and counters are cleared.
- start_i latches N and P, clears the FIFO, token line and counters, and enters WAIT_RAM. This applies in any state, including mid-run.
- start_i takes priority over every other event in the same cycle.
- Total words T = (N+1)*(P+1). Counters are 22 bits wide.
- State machine:
  - IDLE: wait for start_i.
  - WAIT_RAM: wait for bias_ram_ready_i=1.
  - PRIME: one cycle. Injects a capture token for word 0 without pulsing bias_req_o.
  - RUN.
  - DRAIN: all T beats consumed; wait for the output register to empty.
  - DRAIN -> IDLE, pulsing done_o.
- Token line: BIAS_LAT-stage shift register. The cycle a token exits, bias_data_i is pushed into the bias FIFO.
- bias_req_o rules:
  - Never asserted in the PRIME cycle.
  - Asserted in RUN when (FIFO occupancy + tokens in flight) < BIAS_FIFO_DEPTH and words requested (priming included) < T.
  - Each pulse injects a token.
  - Back-to-back pulses are allowed, and they yield consecutive words.
- Accept condition: acc_ready_o = (state==RUN) & FIFO not empty & (~out_valid_o | out_ready_i).
  - acc_ready_o is combinational from registered state.
  - On accept, one bias word is popped and the result is registered: 1-cycle latency to out_valid_o.
- Arithmetic: per lane, sum = sext17(acc) + sext17(bias).
  - Saturate to 16 bits: >32767 gives 32767; <-32768 gives -32768.
- The output register holds its data while out_valid_o & ~out_ready_i.
- Beat counter: increments per accept. When it reaches T, state goes to DRAIN; acc_ready_o=0 from then on.
- Simultaneous FIFO push and pop in the same cycle: occupancy unchanged. Push into a full FIFO cannot occur by construction (credit rule).
- bias_ram_ready_i falling during RUN (controller restarted) is ignored; only start_i restarts this block.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: EXP_BIAS_RELU_EN.
- Defined: after saturation, each negative lane is forced to 0 (ReLU fused).
- Undefined: saturated sum passes through unchanged. Ports and latency are identical in both builds.

Test Plan:
- N=1, P=0; bias words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005; acc beats all lanes 10, out_ready_i=1 -> outputs 0x000E_000D_000C_000B then 0x0012_0011_0010_000F; done_o pulses once; exactly 1 bias_req_o pulse total.
- N=3, P=9, acc_valid_i and out_ready_i held 1 -> after priming, one result per cycle; 40 results; bias lane pattern repeats every 4 beats; no bubble after the first result.
- Saturation: acc lane 0x7FF0 + bias 0x0020 -> 0x7FFF; acc 0x8005 + bias 0xFFF0 -> 0x8000.
- ReLU: acc lane -5, bias 0 -> 0xFFFB without EXP_BIAS_RELU_EN, 0x0000 with it.
- Backpressure: out_ready_i random 50% -> out_data_o stable while stalled; no beat lost or duplicated; FIFO occupancy never exceeds BIAS_FIFO_DEPTH.
- start_i during RUN after 5 beats -> outputs stop; re-prime from word 0 on bias_ram_ready_i; full T results follow; no done_o from the aborted run.

Source files
------------

// File: rtl/exp_bias_add.sv
// rtl/exp_bias_add.sv - bias RAM streamer with prefetch FIFO, lane-wise saturating add; EXP_BIAS_RELU_EN fuses a ReLU
module exp_bias_add #(
   parameter int BIAS_LAT        = 2,
   parameter int BIAS_FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [5:0]  no_of_exp_kernals_i,
   input  logic [15:0] no_of_out_pixels_i,
   input  logic        bias_ram_ready_i,
   output logic        bias_req_o,
   input  logic [63:0] bias_data_i,
   input  logic        acc_valid_i,
   output logic        acc_ready_o,
   input  logic [63:0] acc_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] out_data_o,
   output logic        busy_o,
   output logic        done_o
);
   localparam int PW = (BIAS_FIFO_DEPTH > 1) ? $clog2(BIAS_FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {IDLE, WAIT_RAM, PRIME, RUN, DRAIN} state_t;
   state_t state, state_nxt;

   logic [5:0]          n_q;
   logic [15:0]         p_q;
   logic [21:0]         last_beat;
   logic [21:0]         beat_cnt;
   logic [21:0]         req_cnt;
   logic                req_all;
   logic [BIAS_LAT-1:0] tok;
   logic                tok_in;
   logic [7:0]          inflight;
   logic [63:0]         fifo_mem [BIAS_FIFO_DEPTH];
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic [7:0]          occ;
   logic                push;
   logic                pop;
   logic [63:0]         bias_head;
   logic [63:0]         result;
   logic [16:0]         lane_sum;
   logic [15:0]         lane_val;

   // T-1 fits in 22 bits even when T itself is 2^22, so counters compare against the last index
   assign last_beat = ({16'd0, n_q} + 22'd1) * ({6'd0, p_q} + 22'd1) - 22'd1;
   assign push      = tok[BIAS_LAT-1];
   assign pop       = acc_valid_i & acc_ready_o;
   assign bias_head = fifo_mem[rd_ptr];
   assign busy_o    = (state != IDLE);

   // tokens still travelling through the read-latency line
   always_comb begin
      inflight = '0;
      for (int i = 0; i < BIAS_LAT; i++) inflight = inflight + {7'd0, tok[i]};
   end

   // next state, request credit and accept handshake; start_i overrides everything
   always_comb begin
      state_nxt   = state;
      tok_in      = 1'b0;
      bias_req_o  = 1'b0;
      acc_ready_o = 1'b0;
      done_o      = 1'b0;
      case (state)
         IDLE:     ;
         WAIT_RAM: if (bias_ram_ready_i) state_nxt = PRIME;
         PRIME: begin
            tok_in    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            bias_req_o  = ~req_all & ((occ + inflight) < 8'(BIAS_FIFO_DEPTH));
            tok_in      = bias_req_o;
            acc_ready_o = (occ != 8'd0) & (~out_valid_o | out_ready_i);
            if (acc_valid_i & acc_ready_o & (beat_cnt == last_beat)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!out_valid_o) begin
               done_o    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (start_i) begin
         state_nxt  = WAIT_RAM;
         tok_in     = 1'b0;
         bias_req_o = 1'b0;
         done_o     = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // per-lane 17-bit sum, clamp on sign overflow, optional ReLU
   always_comb begin
      result   = '0;
      lane_sum = '0;
      lane_val = '0;
      for (int k = 0; k < 4; k++) begin
         lane_sum = {acc_data_i[16*k+15], acc_data_i[16*k +: 16]}
                  + {bias_head[16*k+15], bias_head[16*k +: 16]};
         case (lane_sum[16:15])
            2'b01:   lane_val = 16'h7FFF;
            2'b10:   lane_val = 16'h8000;
            default: lane_val = lane_sum[15:0];
         endcase
`ifdef EXP_BIAS_RELU_EN
         if (lane_val[15]) lane_val = 16'h0000;
`endif
         result[16*k +: 16] = lane_val;
      end
   end

   // bias FIFO storage; pointers gate validity so no reset is needed
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= bias_data_i;
   end

   // config latch, token line, FIFO pointers, counters and output register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         n_q         <= '0;
         p_q         <= '0;
         beat_cnt    <= '0;
         req_cnt     <= '0;
         req_all     <= 1'b0;
         tok         <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         occ         <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else if (start_i) begin
         n_q         <= no_of_exp_kernals_i;
         p_q         <= no_of_out_pixels_i;
         beat_cnt    <= '0;
         req_cnt     <= '0;
         req_all     <= 1'b0;
         tok         <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         occ         <= '0;
         out_valid_o <= 1'b0;
      end else begin
         tok[0] <= tok_in;
         for (int i = 1; i < BIAS_LAT; i++) tok[i] <= tok[i-1];
         if (push) wr_ptr <= (wr_ptr == PW'(BIAS_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(BIAS_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         occ <= occ + {7'd0, push} - {7'd0, pop};
         if (state == PRIME) begin
            req_cnt <= 22'd1;
            req_all <= (last_beat == 22'd0);
         end else if (bias_req_o) begin
            req_cnt <= req_cnt + 22'd1;
            if (req_cnt == last_beat) req_all <= 1'b1;
         end
         if (pop) begin
            beat_cnt    <= beat_cnt + 22'd1;
            out_data_o  <= result;
            out_valid_o <= 1'b1;
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end
endmodule
